// File: rtl/tick_prescaler.sv
// ============================================================================
// tick_prescaler
// ----------------------------------------------------------------------------
// Multi-channel, runtime-programmable tick generator. Each channel divides clk
// by (div+1) run-cycles and emits a one-cycle registered tick strobe that
// downstream logic uses as a clock enable. A channel is either periodic
// (free-running) or one-shot (clears its active flag after the tick). The
// global run input pauses every channel without losing its phase.
//
// Parameters:
//   W        counter / divisor width in bits
//   CH       number of independent channels (>= 1)
//   DEF_DIV  divisor loaded into every channel at reset (period DEF_DIV+1)
//   CW       derived channel-index width, max(1, $clog2(CH)); not overridable
//
// Ports:
//   clk          in   1   single clock, rising edge
//   rst          in   1   synchronous, active-high reset
//   run          in   1   global count enable; low holds every counter
//   cfg_we       in   1   configuration write strobe
//   cfg_ch       in   CW  channel index of the write (>= CH is ignored)
//   cfg_div      in   W   divisor to write; period = cfg_div+1 run-cycles
//   cfg_oneshot  in   1   mode to write: 1 = one-shot, 0 = periodic
//   start        in   CH  per-channel arm / restart strobe
//   tick         out  CH  registered one-cycle strobe per channel
//   active       out  CH  registered; channel is armed and counting
//
// Optional feature (compile-time macro):
//   TICK_PRESCALER_CASCADE_EN - when defined, channel i>0 only advances on
//   the terminal cycle of channel i-1, so the channels form a divider chain
//   with a total period equal to the product of (div_j+1). When undefined the
//   channels are fully independent and the cascade logic is absent.
// ============================================================================

module tick_prescaler #(
    parameter int W       = 16,
    parameter int CH      = 4,
    parameter int DEF_DIV = 11,
    localparam int CW     = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_ch,
    input  logic [W-1:0]  cfg_div,
    input  logic          cfg_oneshot,
    input  logic [CH-1:0] start,
    output logic [CH-1:0] tick,
    output logic [CH-1:0] active
);

    // Per-channel state. tick and active are the registered outputs themselves.
    logic [W-1:0]  cnt [CH];
    logic [W-1:0]  div [CH];
    logic [CH-1:0] oneshot;

    // Combinational per-channel qualifiers.
    logic [CH-1:0] adv;
    logic [CH-1:0] term;
    logic [CH-1:0] cfg_hit;

    // adv: the channel counts this cycle. term: the channel is on its last
    // count of the period. In cascade mode the terminal strobe of the previous
    // channel is carried along in a block-local variable so the chain is
    // evaluated in channel order without a combinational self-loop on term.
    // term is taken before the start/cfg priority, so a suppressed tick of
    // channel i-1 still clocks channel i.
    always_comb begin : adv_term_logic
`ifdef TICK_PRESCALER_CASCADE_EN
        logic carry;
        carry = 1'b1;
`endif
        adv  = '0;
        term = '0;
        for (int i = 0; i < CH; i++) begin
`ifdef TICK_PRESCALER_CASCADE_EN
            adv[i] = active[i] & run & carry;
`else
            adv[i] = active[i] & run;
`endif
            term[i] = adv[i] && (cnt[i] == div[i]);
`ifdef TICK_PRESCALER_CASCADE_EN
            carry = term[i];
`endif
        end
    end

    // A configuration write addresses exactly one channel. An index >= CH
    // matches no channel, so such writes fall through with no effect.
    always_comb begin : cfg_decode
        cfg_hit = '0;
        for (int i = 0; i < CH; i++) begin
            cfg_hit[i] = cfg_we && (cfg_ch == i[CW-1:0]);
        end
    end

    // Channel state update. start and cfg writes take priority over counting
    // and both zero the counter, which also drops a tick that would have
    // fired on this edge. When both hit one channel they merge: new config,
    // cnt=0, active=1. cnt never exceeds div because every path that changes
    // div also clears cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                cnt[i]     <= '0;
                div[i]     <= W'(DEF_DIV);
                oneshot[i] <= 1'b0;
                active[i]  <= 1'b1;
                tick[i]    <= 1'b0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (cfg_hit[i]) begin
                    div[i]     <= cfg_div;
                    oneshot[i] <= cfg_oneshot;
                end

                if (cfg_hit[i] || start[i]) begin
                    cnt[i]  <= '0;
                    tick[i] <= 1'b0;
                    if (start[i]) begin
                        active[i] <= 1'b1;
                    end
                end else if (term[i]) begin
                    cnt[i]  <= '0;
                    tick[i] <= 1'b1;
                    if (oneshot[i]) begin
                        active[i] <= 1'b0;
                    end
                end else if (adv[i]) begin
                    cnt[i]  <= cnt[i] + W'(1);
                    tick[i] <= 1'b0;
                end else begin
                    tick[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_prescaler.sv
// ============================================================================
// tb_tick_prescaler
// ----------------------------------------------------------------------------
// Self-checking bench for tick_prescaler (CH=4, W=16, DEF_DIV=11) plus a small
// CH=3 instance for the out-of-range channel index. Every edge is compared
// against a reference model that tracks, per channel, how many more run-cycles
// remain until the next tick. Directed sequences and a vector table hold
// hand-derived expectations; a randomized phase leans on the model.
// Honours TICK_PRESCALER_CASCADE_EN for the cascade checks.
// ============================================================================

module tb_tick_prescaler;

    localparam int W       = 16;
    localparam int CH      = 4;
    localparam int DEF_DIV = 11;

    typedef struct {
        logic          rst;
        logic          run;
        logic          we;
        logic [1:0]    ch;
        logic [W-1:0]  div;
        logic          os;
        logic [CH-1:0] st;
        logic [CH-1:0] et;
        logic [CH-1:0] ea;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic          cfg_we;
    logic [1:0]    cfg_ch;
    logic [W-1:0]  cfg_div;
    logic          cfg_oneshot;
    logic [CH-1:0] start;
    logic [CH-1:0] tick;
    logic [CH-1:0] active;

    logic [2:0]    b_start;
    logic [2:0]    b_tick;
    logic [2:0]    b_active;

    int checks;
    int failures;

    // Reference model: remaining run-cycles to the next tick, per channel.
    int            rem  [CH];
    int            mdiv [CH];
    logic [CH-1:0] mos;
    logic [CH-1:0] mact;
    logic [CH-1:0] mtick;

    always #5 clk = ~clk;

    tick_prescaler #(.W(W), .CH(CH), .DEF_DIV(DEF_DIV)) dut (
        .clk(clk), .rst(rst), .run(run), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot), .start(start),
        .tick(tick), .active(active)
    );

    tick_prescaler #(.W(W), .CH(3), .DEF_DIV(2)) dut_b (
        .clk(clk), .rst(rst), .run(run), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot), .start(b_start),
        .tick(b_tick), .active(b_active)
    );

    function automatic vec_t mk(input logic r, input logic ru, input logic we,
                                input logic [1:0] ch, input logic [W-1:0] d,
                                input logic os, input logic [CH-1:0] st,
                                input logic [CH-1:0] et, input logic [CH-1:0] ea);
        vec_t v;
        v.rst = r; v.run = ru; v.we = we; v.ch = ch; v.div = d;
        v.os = os; v.st = st; v.et = et; v.ea = ea;
        return v;
    endfunction

    task automatic modelStep(input vec_t v);
        logic prevFire;
        logic adv;
        logic fire;
        logic wr;
        prevFire = 1'b1;
        if (v.rst) begin
            for (int i = 0; i < CH; i++) begin
                rem[i]  = DEF_DIV + 1;
                mdiv[i] = DEF_DIV;
            end
            mos   = '0;
            mact  = '1;
            mtick = '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                adv = mact[i] && v.run;
`ifdef TICK_PRESCALER_CASCADE_EN
                adv = adv && prevFire;
`endif
                fire     = adv && (rem[i] == 1);
                prevFire = fire;
                wr       = v.we && (int'(v.ch) == i);
                mtick[i] = 1'b0;
                if (wr) begin
                    mdiv[i] = int'(v.div);
                    mos[i]  = v.os;
                end
                if (wr || v.st[i]) begin
                    rem[i] = mdiv[i] + 1;
                    if (v.st[i]) mact[i] = 1'b1;
                end else if (adv) begin
                    rem[i] = rem[i] - 1;
                    if (rem[i] == 0) begin
                        mtick[i] = 1'b1;
                        rem[i]   = mdiv[i] + 1;
                        if (mos[i]) mact[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [3:0] act,
                               input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b at time %0t", name, act, exp, $time);
        end
    endtask

    // Drive one edge's worth of inputs, advance the model, compare DUT to it.
    task automatic applyStimulus(input vec_t v);
        rst = v.rst; run = v.run; cfg_we = v.we; cfg_ch = v.ch;
        cfg_div = v.div; cfg_oneshot = v.os; start = v.st;
        @(posedge clk);
        modelStep(v);
        #1;
        checkOutput("model_tick", tick, mtick);
        checkOutput("model_active", active, mact);
    endtask

    task automatic doReset();
        applyStimulus(mk(1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'd0, 4'd0, 4'd0));
    endtask

    task automatic tickRun(input logic ru);
        applyStimulus(mk(1'b0, ru, 1'b0, 2'd0, 16'd0, 1'b0, 4'd0, 4'd0, 4'd0));
    endtask

    initial begin
        vec_t          vecs [17];
        logic [CH-1:0] mask;
        vec_t          rv;

        checks   = 0;
        failures = 0;
        rst = 1'b1; run = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0;
        cfg_div = '0; cfg_oneshot = 1'b0; start = '0; b_start = '0;
        for (int i = 0; i < CH; i++) begin
            rem[i] = DEF_DIV + 1; mdiv[i] = DEF_DIV;
        end
        mos = '0; mact = '1; mtick = '0;

        // Reset state and free-run from reset: first tick at edge 12.
        doReset();
        doReset();
        checkOutput("reset_tick", tick, 4'h0);
        checkOutput("reset_active", active, 4'hf);
`ifdef TICK_PRESCALER_CASCADE_EN
        mask = 4'b0001;
`else
        mask = 4'b1111;
`endif
        for (int e = 1; e <= 36; e++) begin
            tickRun(1'b1);
            checkOutput("free_run_tick", tick & mask, (e % 12 == 0) ? mask : 4'h0);
            checkOutput("free_run_active", active, 4'hf);
        end

`ifndef TICK_PRESCALER_CASCADE_EN
        // Vector table: ch1 div=2 with a run-low gap, then ch3 div=0.
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'd0, 4'h0, 4'hf);
        vecs[1]  = mk(1'b0, 1'b1, 1'b1, 2'd1, 16'd2, 1'b0, 4'd0, 4'h0, 4'hf);
        vecs[2]  = mk(1'b0, 1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 4'd0, 4'h0, 4'hf);
        vecs[3]  = mk(1'b0, 1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 4'd0, 4'h0, 4'hf);
        vecs[4]  = mk(1'b0, 1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 4'd0, 4'h2, 4'hf);
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'd0, 4'h0, 4'hf);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'd0, 4'h0, 4'hf);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'd0, 4'h0, 4'hf);
        vecs[8]  = mk(1'b0, 1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 4'd0, 4'h0, 4'hf);
        vecs[9]  = mk(1'b0, 1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 4'd0, 4'h0, 4'hf);
        vecs[10] = mk(1'b0, 1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 4'd0, 4'h2, 4'hf);
        vecs[11] = mk(1'b0, 1'b1, 1'b1, 2'd3, 16'd0, 1'b0, 4'd0, 4'h0, 4'hf);
        vecs[12] = mk(1'b0, 1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 4'd0, 4'h8, 4'hf);
        vecs[13] = mk(1'b0, 1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 4'd0, 4'ha, 4'hf);
        vecs[14] = mk(1'b0, 1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 4'd0, 4'h8, 4'hf);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'd0, 4'h0, 4'hf);
        vecs[16] = mk(1'b0, 1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 4'd0, 4'hd, 4'hf);
        for (int n = 0; n < 17; n++) begin
            applyStimulus(vecs[n]);
            checkOutput("vec_tick", tick, vecs[n].et);
            checkOutput("vec_active", active, vecs[n].ea);
        end

        // One-shot on ch2, div=4: armed from reset, then start, then restart.
        doReset();
        applyStimulus(mk(1'b0, 1'b1, 1'b1, 2'd2, 16'd4, 1'b1, 4'd0, 4'd0, 4'd0));
        checkOutput("os_cfg_active", {3'b0, active[2]}, 4'h1);
        for (int k = 1; k <= 8; k++) begin
            tickRun(1'b1);
            checkOutput("os_armed_tick", {3'b0, tick[2]}, (k == 5) ? 4'h1 : 4'h0);
            checkOutput("os_armed_active", {3'b0, active[2]}, (k < 5) ? 4'h1 : 4'h0);
        end
        applyStimulus(mk(1'b0, 1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0100, 4'd0, 4'd0));
        checkOutput("os_start_active", {3'b0, active[2]}, 4'h1);
        for (int k = 1; k <= 7; k++) begin
            tickRun(1'b1);
            checkOutput("os_start_tick", {3'b0, tick[2]}, (k == 5) ? 4'h1 : 4'h0);
            checkOutput("os_start_active", {3'b0, active[2]}, (k < 5) ? 4'h1 : 4'h0);
        end
        applyStimulus(mk(1'b0, 1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0100, 4'd0, 4'd0));
        tickRun(1'b1);
        tickRun(1'b1);
        applyStimulus(mk(1'b0, 1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0100, 4'd0, 4'd0));
        checkOutput("os_restart_tick", {3'b0, tick[2]}, 4'h0);
        for (int k = 1; k <= 6; k++) begin
            tickRun(1'b1);
            checkOutput("os_restart_tick", {3'b0, tick[2]}, (k == 5) ? 4'h1 : 4'h0);
        end
`endif

        // Combined cfg+start on ch0, then reset on a would-be tick edge.
        doReset();
        for (int k = 0; k < 5; k++) tickRun(1'b1);
        applyStimulus(mk(1'b0, 1'b1, 1'b1, 2'd0, 16'd1, 1'b0, 4'b0001, 4'd0, 4'd0));
        checkOutput("combo_tick", {3'b0, tick[0]}, 4'h0);
        checkOutput("combo_active", {3'b0, active[0]}, 4'h1);
        for (int e = 1; e <= 5; e++) begin
            tickRun(1'b1);
            checkOutput("combo_div1_tick", {3'b0, tick[0]}, (e % 2 == 0) ? 4'h1 : 4'h0);
        end
        applyStimulus(mk(1'b1, 1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 4'd0, 4'd0, 4'd0));
        checkOutput("rst_mid_tick", tick, 4'h0);
        checkOutput("rst_mid_active", active, 4'hf);
        for (int e = 1; e <= 12; e++) begin
            tickRun(1'b1);
            checkOutput("rst_div_restore", {3'b0, tick[0]}, (e == 12) ? 4'h1 : 4'h0);
        end

`ifdef TICK_PRESCALER_CASCADE_EN
        // Cascade: div0=3, div1=2 gives tick[1] on every third tick[0].
        doReset();
        applyStimulus(mk(1'b0, 1'b1, 1'b1, 2'd0, 16'd3, 1'b0, 4'd0, 4'd0, 4'd0));
        applyStimulus(mk(1'b0, 1'b1, 1'b1, 2'd1, 16'd2, 1'b0, 4'd0, 4'd0, 4'd0));
        for (int e = 1; e <= 24; e++) begin
            tickRun(1'b1);
            checkOutput("cascade_tick0", {3'b0, tick[0]}, ((1 + e) % 4 == 0) ? 4'h1 : 4'h0);
            checkOutput("cascade_tick1", {3'b0, tick[1]}, ((1 + e) % 12 == 0) ? 4'h1 : 4'h0);
        end
`endif

        // CH=3 instance: writes to channel index 3 must change nothing.
        doReset();
        for (int e = 1; e <= 6; e++) begin
            applyStimulus(mk(1'b0, 1'b1, 1'b1, 2'd3, 16'd0, 1'b0, 4'd0, 4'd0, 4'd0));
            checkOutput("oor_tick", {1'b0, b_tick}, (e % 3 == 0) ? 4'h7 : 4'h0);
            checkOutput("oor_active", {1'b0, b_active}, 4'h7);
        end

        // Randomized traffic against the model.
        doReset();
        for (int n = 0; n < 600; n++) begin
            rv = mk(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 11) == 0), 2'($urandom_range(0, 3)),
                    16'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
                    4'd0, 4'd0);
            applyStimulus(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
